// File: rtl/zap_wb_mem_slave.sv
// Wishbone B3 slave backed by a word RAM: classic cycles and linear incrementing bursts,
// programmable initial wait states, error response for out-of-range or misaligned addresses.
module zap_wb_mem_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] addr;
  logic        wen;
  logic [3:0]  cnt;
  logic [31:0] next_addr;

  function automatic logic illegal(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return ((off >> 2) >= 32'(DEPTH_WORDS)) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [AW-1:0] index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  assign next_addr = addr + 32'd4;

  // Control FSM; ack/err/dat are registered so the master sees them one edge after the decision
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= 32'h0;
      cnt      <= 4'd0;
      addr     <= 32'h0;
      wen      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            addr <= i_wb_adr;
            wen  <= i_wb_wen;
            if (illegal(i_wb_adr)) begin
              o_wb_err <= 1'b1;
              state    <= ERR;
            end else if (WAIT_STATES == 0) begin
              o_wb_ack <= 1'b1;
              o_wb_dat <= mem[index(i_wb_adr)];
              state    <= ACK;
            end else begin
              cnt   <= 4'(WAIT_STATES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            o_wb_ack <= 1'b1;
            o_wb_dat <= mem[index(addr)];
            state    <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          if (!i_wb_cyc) begin
            o_wb_ack <= 1'b0;
            state    <= IDLE;
          end else if (!i_wb_stb) begin
            o_wb_ack <= 1'b0;
          end else if (!o_wb_ack) begin
            // Resuming after a stall: re-present the same address with no wait states
            o_wb_ack <= 1'b1;
            o_wb_dat <= mem[index(addr)];
          end else if (i_wb_cti == 3'b010) begin
            addr <= next_addr;
            if (illegal(next_addr)) begin
              o_wb_ack <= 1'b0;
              o_wb_err <= 1'b1;
              state    <= ERR;
            end else begin
              o_wb_dat <= mem[index(next_addr)];
            end
          end else begin
            o_wb_ack <= 1'b0;
            state    <= IDLE;
          end
        end
        ERR: begin
          o_wb_err <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write commits on the accepted beat; reset clears ack asynchronously, so an aborted beat never writes
  always_ff @(posedge i_clk) begin
    if (o_wb_ack && i_wb_cyc && i_wb_stb && wen) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) mem[index(addr)][8*b +: 8] <= i_wb_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_zap_wb_mem_slave.sv
// Randomized Wishbone master with a word-array reference model; a monitor process checks
// each acknowledged/errored beat against a queue of expected responses.
module tb_zap_wb_mem_slave;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          WS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, wen;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [2:0]  cti;
  logic [31:0] rdat;
  logic        ack, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wd [8];
  logic [3:0]  ws [8];

  zap_wb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_wen(wen),
    .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_cti(cti),
    .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && ((off / 4) < 32'(DEPTH));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off / 4;
  endfunction

  // Monitor: every beat the DUT responds to while the master strobes is matched against the queue
  always @(negedge clk) begin
    if (!rst && cyc && stb && (ack || err)) begin
      exp_t e;
      chk("ack_err_exclusive", {31'b0, ack & err}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_response", {30'b0, ack, err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("resp_kind", {31'b0, err}, {31'b0, e.is_err});
        if (e.chk_dat && !e.is_err) chk("read_data", rdat, e.dat);
      end
    end
  end

  // One bus cycle: n beats from start; abort_after>0 drops cyc after that many beats
  task automatic xfer(input logic [31:0] start, input int n, input logic we,
                      input int abort_after, input bit stalls);
    logic [31:0] a;
    int          lat;
    int          exp_lat;
    bit          stalled;
    bit          stop;
    bit          aborted;
    exp_t        e;
    stop    = 1'b0;
    aborted = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < n && !stop; i++) begin
      a       = start + 32'(4 * i);
      stalled = 1'b0;
      if (stalls && i > 0 && legal(a) && $urandom_range(0, 2) == 0) begin
        stb = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        stalled = 1'b1;
      end
      e.is_err  = !legal(a);
      e.chk_dat = !we;
      e.dat     = 32'h0;
      if (legal(a)) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (ws[i][b]) model[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
        end else begin
          e.dat = model[widx(a)];
        end
      end
      q.push_back(e);
      cyc  = 1'b1;
      stb  = 1'b1;
      wen  = we;
      adr  = a;
      wdat = wd[i];
      sel  = ws[i];
      cti  = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      exp_lat = (i == 0) ? (legal(a) ? WS + 2 : 2) : (stalled ? 2 : 1);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!(ack || err) && lat < 64);
      if (!(ack || err)) begin
        checks++;
        errors++;
        $display("FAIL response_timeout: no ack/err after %0d cycles at adr %h", lat, a);
        stop = 1'b1;
      end else begin
        chk("beat_latency", 32'(lat), 32'(exp_lat));
        if (err) stop = 1'b1;
      end
      if (abort_after == i + 1) begin
        stop    = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
    end
    cyc = 1'b0;
    stb = 1'b0;
    cti = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!(aborted && k == 0)) chk("idle_after_cycle", {30'b0, ack, err}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; wen = 1'b0;
    sel = 4'h0; adr = 32'h0; wdat = 32'h0; cti = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_dat", rdat, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Bring the whole RAM to a known state with full-word write bursts
    for (int w = 0; w < DEPTH; w += 8) begin
      for (int j = 0; j < 8; j++) begin
        wd[j] = $urandom;
        ws[j] = 4'hf;
      end
      xfer(32'(w * 4), 8, 1'b1, 0, 1'b0);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hf;
    xfer(32'hC, 1, 1'b1, 0, 1'b0);
    xfer(32'hC, 1, 1'b0, 0, 1'b0);

    wd[0] = 32'h11223344; ws[0] = 4'hf;
    xfer(32'h0, 1, 1'b1, 0, 1'b0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0010;
    xfer(32'h0, 1, 1'b1, 0, 1'b0);
    xfer(32'h0, 1, 1'b0, 0, 1'b0);

    xfer(32'h20, 8, 1'b0, 0, 1'b0);

    xfer(BASE + 32'(4 * DEPTH), 1, 1'b0, 0, 1'b0);
    xfer(BASE + 32'(4 * (DEPTH - 1)), 2, 1'b0, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      wd[j] = $urandom;
      ws[j] = 4'hf;
    end
    xfer(32'h40, 4, 1'b1, 2, 1'b0);
    xfer(32'h40, 4, 1'b0, 0, 1'b0);

    // Reset during the wait phase of a write: outputs clear at once, the word stays intact
    xfer(32'hC, 1, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; wen = 1'b1; adr = 32'h14;
    wdat = 32'hCAFEF00D; sel = 4'hf; cti = 3'b000;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midwait_reset_ack", {31'b0, ack}, 32'd0);
    chk("midwait_reset_err", {31'b0, err}, 32'd0);
    chk("midwait_reset_dat", rdat, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; wen = 1'b0;
    xfer(32'h14, 1, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int          n;
      logic        we;
      a = 32'($urandom_range(0, DEPTH + 1)) * 32'd4 + BASE;
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      n  = $urandom_range(1, 8);
      we = 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) begin
        wd[j] = $urandom;
        ws[j] = 4'($urandom);
      end
      xfer(a, n, we, 0, 1'b1);
    end

    for (int w = 0; w < DEPTH; w += 8) xfer(32'(w * 4) + BASE, 8, 1'b0, 0, 1'b1);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
